// File: rtl/demux3.sv
// Registered 1-to-8 write distributor: routes in_data to the slot chosen by control,
// each slot a one-entry valid/ready buffer. Define DEMUX3_OVERWRITE_EN for overwrite mode.

module demux3_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             full_next
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drain;

  assign drain = (state_q == FULL) & rd_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    // A write wins over a drain, which yields write-through on a same-cycle pair
    if (wr_en) begin
      state_d = FULL;
      data_d  = wr_data;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data      = data_q;
  assign full      = (state_q == FULL);
  assign full_next = (state_d == FULL);
endmodule

module demux3 #(
  parameter int WIDTH = 16,
  parameter int SLOTS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [SLOTS-1:0] out_valid,
  input  logic [SLOTS-1:0] out_ready,
  output logic [3:0]       count,
  output logic             overflow
);
  logic [SLOTS-1:0]            sel;
  logic [SLOTS-1:0]            wr_en;
  logic [SLOTS-1:0]            full;
  logic [SLOTS-1:0]            full_next;
  logic [SLOTS-1:0][WIDTH-1:0] slot_data;
  logic                        accept;
  logic [3:0]                  count_q, count_d;

  always_comb begin
    sel = '0;
    sel[control] = 1'b1;
  end

`ifdef DEMUX3_OVERWRITE_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = ~full[control] | out_ready[control];
`endif

  assign accept = in_valid & in_ready;
  assign wr_en  = {SLOTS{accept}} & sel;

  genvar k;
  generate
    for (k = 0; k < SLOTS; k++) begin : g_slot
      demux3_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en[k]),
        .wr_data   (in_data),
        .rd_ready  (out_ready[k]),
        .data      (slot_data[k]),
        .full      (full[k]),
        .full_next (full_next[k])
      );
    end
  endgenerate

  // Count is the popcount of next-cycle occupancy so it registers in step with out_valid
  always_comb begin
    count_d = '0;
    for (int i = 0; i < SLOTS; i++) count_d = count_d + {3'b000, full_next[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

`ifdef DEMUX3_OVERWRITE_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (accept & full[control] & ~out_ready[control]) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign out_valid = full;
  assign count     = count_q;
  assign o0 = slot_data[0];
  assign o1 = slot_data[1];
  assign o2 = slot_data[2];
  assign o3 = slot_data[3];
  assign o4 = slot_data[4];
  assign o5 = slot_data[5];
  assign o6 = slot_data[6];
  assign o7 = slot_data[7];
endmodule
